multi_tick_divider: RTL and testbench
=====================================

// Module: multi_tick_divider
// PURPOSE
//  N-channel programmable frequency divider; each channel emits a one-cycle tick every DIV clk cycles
//  plus a near-50% square wave. Divisors are runtime-loadable and applied glitch-free at period wrap.
//  A global sync input realigns all channels. Feeds the clock/display timebase (1 Hz, blink, scan).
// PARAMETERS
//  N_CH         4         number of independent channels (1..16)
//  CNT_W        26        counter/divisor width in bits; must hold DEFAULT_DIV-1
//  DEFAULT_DIV  50000000  divisor loaded into every channel at reset
// PORTS
//  clk      in   1                 system clock; one clock domain only
//  reset    in   1                 reset is asynchronous and active-low
//  en       in   N_CH              per-channel enable
//  cfg_we   in   1                 one-cycle strobe: write cfg_div to channel cfg_ch
//  cfg_ch   in   max(1,clog2 N_CH) target channel; values >= N_CH are ignored
//  cfg_div  in   CNT_W             new divisor; 0 is treated as 1
//  sync     in   1                 restart all enabled channels from count 0
//  tick     out  N_CH              one-cycle pulse per period
//  square   out  N_CH              high for the first ceil(DIV/2) cycles of each period
//  pending  out  N_CH              shadow divisor written but not yet active
// BEHAVIOUR
//  - Reset (reset=0, async assert, sync deassert inside block):
//    cnt=0, div_act=div_shd=DEFAULT_DIV, pending=0, tick=0, square=0.
//  - Per channel i, with en[i]=1: cnt counts 0..div_act-1 and wraps to 0.
//    tick[i]=(cnt==div_act-1); square[i]=(cnt<half_act), half_act=(div_act+1)>>1.
//    Both are combinational decodes of registers only; no path from inputs to outputs.
//  - en[i]=0: cnt held at 0, tick=0, square=0; a pending divisor is applied on the next clk.
//    After en rises, the first tick is div_act cycles later (cycle div_act-1 counting en-rise as 0).
//  - Config write: cfg_we with a valid cfg_ch loads div_shd, sets pending.
//    At the wrap edge (cnt==div_act-1), div_act<=div_shd, half_act recomputed, pending cleared,
//    and cnt<=0. The current period always completes with the old divisor.
//  - A write on the same cycle as a wrap: the new value takes effect at that wrap. Last write wins.
//  - sync=1: every channel's cnt<=0; pending divisors are applied on the same edge.
//    A cfg_we on the same cycle as sync is applied too. No tick is emitted on the sync cycle edge itself.
//  - Divisor 1 (or 0): tick and square are constantly 1 while enabled.
//  - Width: cfg_div is truncated to CNT_W. Compare div_act-1 in CNT_W bits; the 0->1 mapping avoids underflow.
//  - Reset mid-operation: all state returns to reset values immediately. Writes in flight are lost.
// STRUCTURE
//  - Shared package tick_div_pkg:
//    clog2 function; DEFAULT_DIV_50MHZ=50000000; DIV_1HZ, DIV_2HZ, DIV_1KHZ constants for 50 MHz clk.
//  - One sub-module, tick_div_channel (cnt, div_shd, div_act, half_act, pending), instantiated N_CH
//    times by generate.
//  - Top holds the cfg address decode and the reset synchroniser.
// TESTING (DEFAULT_DIV overridden to 8 for sim; N_CH=4)
//  1. Reset released, en=4'hF -> all tick every 8 cycles, first at cycle 7; square high 4 cycles, low 4.
//  2. Write ch0 div=3 at cnt=2 -> pending[0]=1; next 5 cycles unchanged.
//     Tick at cnt=7, then period 3: square 2 high / 1 low. Other channels unchanged.
//  3. Write ch1 div=0, then div=1 -> after wrap, tick[1] and square[1] stay high.
//     A cfg_ch=5 write is ignored; no pending bit is set.
//  4. Channels at mixed counts, pulse sync -> all cnt=0 next cycle; ticks coincide 8 cycles after sync.
//     A pending write is applied at sync.
//  5. Drop en[2] mid-period, write div=5, raise en -> tick[2] 5 cycles after en rise; pending cleared while disabled.
//  6. Assert reset asynchronously mid-period, between clk edges -> tick, square, pending go to 0 without a clk edge.
//     After release, period is back to 8.

Source files
------------

// File: rtl/tick_div_pkg.sv
// Shared definitions for the multi-channel tick divider: width helpers,
// channel run state and divisor constants for a 50 MHz system clock.
package tick_div_pkg;

  localparam int unsigned DEFAULT_DIV_50MHZ = 50_000_000;
  localparam int unsigned DIV_1HZ           = 50_000_000;
  localparam int unsigned DIV_2HZ           = 25_000_000;
  localparam int unsigned DIV_1KHZ          = 50_000;

  // Channel is either parked (held at count 0) or counting.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Channel-select width: never narrower than one bit.
  function automatic int ch_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, shadow/active divisor pair and the
// register-only decode of tick and square.
module tick_div_channel
  import tick_div_pkg::*;
#(
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_50MHZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             square,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'((DEFAULT_DIV + 1) / 2);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_shd, div_shd_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] half_act, half_nxt;
  logic             pend_q, pend_nxt;
  logic [CNT_W-1:0] wr_val;
  logic [CNT_W:0]   half_sum;
  logic             last;

  // Last count of the period; div_act is never 0, so the subtraction cannot wrap.
  assign last = (cnt == div_act - CNT_W'(1));

  // Next-state: disabled channels park at 0 and absorb a pending divisor,
  // enabled channels count and swap divisors only at wrap or sync.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_val      = (wr_div == '0) ? CNT_W'(1) : wr_div;
    div_shd_nxt = wr ? wr_val : div_shd;
    div_act_nxt = div_act;
    pend_nxt    = pend_q | wr;

    if (!en) begin
      state_nxt = CH_IDLE;
      cnt_nxt   = '0;
      // A write landing on this same edge stays pending for the next one.
      if (pend_q) begin
        div_act_nxt = div_shd;
        pend_nxt    = wr;
      end
    end else begin
      state_nxt = CH_RUN;
      if (sync) begin
        cnt_nxt     = '0;
        div_act_nxt = div_shd_nxt;
        pend_nxt    = 1'b0;
      end else if (state == CH_RUN) begin
        if (last) begin
          cnt_nxt     = '0;
          div_act_nxt = div_shd_nxt;
          pend_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end

    half_sum = {1'b0, div_act_nxt} + (CNT_W + 1)'(1);
    half_nxt = half_sum[CNT_W:1];
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      div_shd  <= DIV_RST;
      div_act  <= DIV_RST;
      half_act <= HALF_RST;
      pend_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_shd  <= div_shd_nxt;
      div_act  <= div_act_nxt;
      half_act <= half_nxt;
      pend_q   <= pend_nxt;
    end
  end

  assign tick    = (state == CH_RUN) && last;
  assign square  = (state == CH_RUN) && (cnt < half_act);
  assign pending = pend_q;

endmodule

// File: rtl/multi_tick_divider.sv
// N-channel programmable tick/square divider. Holds the reset synchroniser
// and the configuration address decode; the per-channel work lives in
// tick_div_channel.
module multi_tick_divider
  import tick_div_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_50MHZ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         en,
  input  logic                    cfg_we,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  input  logic                    sync,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         square,
  output logic [N_CH-1:0]         pending
);

  localparam int CH_W = ch_w(N_CH);

  logic [1:0]      rst_pipe;
  logic            rst_n;
  logic [N_CH-1:0] wr_sel;

  // Reset synchroniser: assertion propagates at once, release waits two clk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Channel select; codes at or above N_CH match nothing and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr_sel[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g]),
      .square  (square[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed bench for multi_tick_divider with DEFAULT_DIV = 8. A second,
// three-channel instance covers the out-of-range channel code and divisor 0.
module tb_multi_tick_divider;

  localparam int N_CH  = 4;
  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       en = 4'hF;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = 2'd0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             sync = 1'b0;
  logic [3:0]       tick, square, pending;

  logic [2:0]       en_o = 3'b000;
  logic             cfg_we_o = 1'b0;
  logic [1:0]       cfg_ch_o = 2'd0;
  logic [CNT_W-1:0] cfg_div_o = '0;
  logic             sync_o = 1'b0;
  logic [2:0]       tick_o, square_o, pending_o;

  int n_cmp  = 0;
  int n_fail = 0;

  multi_tick_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(8)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .sync(sync), .tick(tick), .square(square), .pending(pending)
  );

  multi_tick_divider #(.N_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(8)) dut_odd (
    .clk(clk), .reset(reset), .en(en_o), .cfg_we(cfg_we_o), .cfg_ch(cfg_ch_o),
    .cfg_div(cfg_div_o), .sync(sync_o), .tick(tick_o), .square(square_o), .pending(pending_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       en;
    logic             we;
    logic [1:0]       ch;
    logic [CNT_W-1:0] div;
    logic             sync;
    logic [3:0]       tick;
    logic [3:0]       sq;
    logic [3:0]       pend;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(input logic [3:0] e, input logic w, input logic [1:0] c,
                              input int d, input logic s, input logic [3:0] t,
                              input logic [3:0] q, input logic [3:0] p);
    vec_t v;
    v.en = e; v.we = w; v.ch = c; v.div = CNT_W'(d); v.sync = s;
    v.tick = t; v.sq = q; v.pend = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of main-instance inputs at negedge, sample #1 after posedge.
  task automatic step(input logic [3:0] e, input logic w, input logic [1:0] c,
                      input int d, input logic s);
    @(negedge clk);
    en = e; cfg_we = w; cfg_ch = c; cfg_div = CNT_W'(d); sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step_odd(input logic [2:0] e, input logic w, input logic [1:0] c, input int d);
    @(negedge clk);
    en_o = e; cfg_we_o = w; cfg_ch_o = c; cfg_div_o = CNT_W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].en, vecs[i].we, vecs[i].ch, int'(vecs[i].div), vecs[i].sync);
      check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d square", i), 32'(square), 32'(vecs[i].sq));
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].pend));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int found;
    int t_first, t_second;

    // Period 8 from enable; ch0 gets div 3 while its count shows 2.
    vecs[0]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[1]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[2]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[3]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[4]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[6]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mk(4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    vecs[8]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[9]  = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[10] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[11] = mk(4'hF, 1, 0, 3, 0, 4'h0, 4'hF, 4'h1);
    vecs[12] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
    vecs[13] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
    vecs[14] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
    vecs[15] = mk(4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 4'h1);
    vecs[16] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[17] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[18] = mk(4'hF, 0, 0, 0, 0, 4'h1, 4'hE, 4'h0);
    vecs[19] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[20] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0);
    vecs[21] = mk(4'hF, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    vecs[22] = mk(4'hF, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0);
    vecs[23] = mk(4'hF, 0, 0, 0, 0, 4'hE, 4'h1, 4'h0);
    vecs[24] = mk(4'hF, 0, 0, 0, 0, 4'h1, 4'hE, 4'h0);
    // Sync with a same-cycle write of div 4 to ch2; divisors are 3,1,4,8.
    vecs[25] = mk(4'hF, 1, 2, 4, 1, 4'h2, 4'hF, 4'h0);
    vecs[26] = mk(4'hF, 0, 0, 0, 0, 4'h2, 4'hF, 4'h0);
    vecs[27] = mk(4'hF, 0, 0, 0, 0, 4'h3, 4'hA, 4'h0);
    vecs[28] = mk(4'hF, 0, 0, 0, 0, 4'h6, 4'hB, 4'h0);
    vecs[29] = mk(4'hF, 0, 0, 0, 0, 4'h2, 4'h7, 4'h0);
    vecs[30] = mk(4'hF, 0, 0, 0, 0, 4'h3, 4'h6, 4'h0);
    vecs[31] = mk(4'hF, 0, 0, 0, 0, 4'h2, 4'h3, 4'h0);
    vecs[32] = mk(4'hF, 0, 0, 0, 0, 4'hE, 4'h3, 4'h0);

    // Reset state, even with every channel enabled.
    repeat (3) @(posedge clk);
    #1;
    check("reset tick", 32'(tick), 32'h0);
    check("reset square", 32'(square), 32'h0);
    check("reset pending", 32'(pending), 32'h0);
    @(negedge clk);
    en = 4'h0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("released idle square", 32'(square), 32'h0);

    run_vecs(0, 24);

    // ch1: div 0 then div 1, both pending until ch1's wrap.
    step(4'hF, 1, 1, 0, 0);
    check("ch1 pending after div0", 32'(pending[1]), 32'h1);
    step(4'hF, 1, 1, 1, 0);
    check("ch1 pending after div1", 32'(pending[1]), 32'h1);
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      step(4'hF, 0, 0, 0, 0);
      if (!pending[1]) found = 1;
    end
    check("ch1 pending clears at wrap", 32'(found), 32'h1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ch1 div1 tick/square %0d", k), 32'({tick[1], square[1]}), 32'h3);
      step(4'hF, 0, 0, 0, 0);
    end

    // Three-channel instance: code 3 is out of range; div 0 behaves as 1.
    step_odd(3'b000, 1, 3, 5);
    check("odd invalid ch pending", 32'(pending_o), 32'h0);
    step_odd(3'b000, 1, 0, 0);
    check("odd ch0 pending set", 32'(pending_o), 32'h1);
    step_odd(3'b000, 0, 0, 0);
    check("odd ch0 applied while disabled", 32'(pending_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step_odd(3'b001, 0, 0, 0);
      check($sformatf("odd ch0 div0 tick/square %0d", k), 32'({tick_o[0], square_o[0]}), 32'h3);
    end

    run_vecs(25, 32);

    // ch2 disabled mid-period, reprogrammed to 5, re-enabled.
    step(4'b1011, 0, 0, 0, 0);
    check("ch2 disabled tick/square", 32'({tick[2], square[2]}), 32'h0);
    step(4'b1011, 1, 2, 5, 0);
    check("ch2 pending while disabled", 32'(pending[2]), 32'h1);
    step(4'b1011, 0, 0, 0, 0);
    check("ch2 pending cleared while disabled", 32'(pending[2]), 32'h0);
    found = -1;
    for (int j = 0; j < 7 && found < 0; j++) begin
      step(4'hF, 0, 0, 0, 0);
      if (j == 0) check("ch2 square after en rise", 32'(square[2]), 32'h1);
      if (tick[2]) found = j;
    end
    check("ch2 first tick cycle after en", 32'(found), 32'h4);

    // Asynchronous reset between clock edges with a write pending.
    step(4'hF, 0, 0, 0, 1);
    step(4'hF, 1, 3, 6, 0);
    check("ch3 pending before reset", 32'(pending[3]), 32'h1);
    check("ch3 square before reset", 32'(square[3]), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("async reset tick", 32'(tick), 32'h0);
    check("async reset square", 32'(square), 32'h0);
    check("async reset pending", 32'(pending), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    en = 4'hF;
    cfg_we = 1'b0;
    t_first = -1;
    t_second = -1;
    for (int c = 0; c < 40 && t_second < 0; c++) begin
      @(posedge clk);
      #1;
      if (tick[3]) begin
        if (t_first < 0) t_first = c;
        else begin
          t_second = c;
          check("post-reset all channels tick together", 32'(tick), 32'hF);
        end
      end
    end
    check("post-reset second tick seen", 32'(t_second >= 0), 32'h1);
    check("post-reset period", 32'(t_second - t_first), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
